// File: rtl/button_debouncer_if.sv
// Signal bundle between the raw button pad and the debouncer outputs.
// The master side drives the pin; the slave side is the debouncer.
interface button_debouncer_if;
   logic btn_n;
   logic pressed;
   logic press_pulse;
   logic release_pulse;
   logic long_pulse;
   logic toggle;

   modport master (
      output btn_n,
      input  pressed,
      input  press_pulse,
      input  release_pulse,
      input  long_pulse,
      input  toggle
   );

   modport slave (
      input  btn_n,
      output pressed,
      output press_pulse,
      output release_pulse,
      output long_pulse,
      output toggle
   );
endinterface

// File: rtl/button_debouncer.sv
// Synchronises and debounces an active-low push button into level, edge pulses and a toggle.
// Define LONG_PRESS_EN to build the hold counter and long_pulse output.
module button_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES   = 16,
   parameter int unsigned LONG_PRESS_CYCLES = 1024
) (
   input logic                clk,
   input logic                rst,
   button_debouncer_if.slave  btn_if
);

   localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES < 1) begin : g_param_check
      $error("button_debouncer: DEBOUNCE_CYCLES must be >= 2 and LONG_PRESS_CYCLES >= 1");
   end

   typedef enum logic [1:0] {StIdle, StPressWait, StHeld, StReleaseWait} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            sync1_q, sync2_q;
   logic            pressed_q, pressed_d;
   logic            press_pulse_q, press_pulse_d;
   logic            release_pulse_q, release_pulse_d;
   logic            toggle_q, toggle_d;
   logic            btn_s;

   assign btn_s = ~sync2_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q         <= 1'b1;
         sync2_q         <= 1'b1;
         state_q         <= StIdle;
         cnt_q           <= '0;
         pressed_q       <= 1'b0;
         press_pulse_q   <= 1'b0;
         release_pulse_q <= 1'b0;
         toggle_q        <= 1'b0;
      end else begin
         sync1_q         <= btn_if.btn_n;
         sync2_q         <= sync1_q;
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         pressed_q       <= pressed_d;
         press_pulse_q   <= press_pulse_d;
         release_pulse_q <= release_pulse_d;
         toggle_q        <= toggle_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      pressed_d       = pressed_q;
      press_pulse_d   = 1'b0;
      release_pulse_d = 1'b0;
      toggle_d        = toggle_q;
      unique case (state_q)
         StIdle: begin
            if (btn_s) begin
               state_d = StPressWait;
               cnt_d   = '0;
            end
         end
         StPressWait: begin
            if (!btn_s) begin
               state_d = StIdle;
            end else if (cnt_q == CntMax) begin
               state_d       = StHeld;
               press_pulse_d = 1'b1;
               pressed_d     = 1'b1;
               toggle_d      = ~toggle_q;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StHeld: begin
            if (!btn_s) begin
               state_d = StReleaseWait;
               cnt_d   = '0;
            end
         end
         StReleaseWait: begin
            // A press seen here is a bounce on release: stay logically pressed.
            if (btn_s) begin
               state_d = StHeld;
            end else if (cnt_q == CntMax) begin
               state_d         = StIdle;
               release_pulse_d = 1'b1;
               pressed_d       = 1'b0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

`ifdef LONG_PRESS_EN
   localparam int unsigned     HcntW    = $clog2(LONG_PRESS_CYCLES + 1);
   localparam logic [HcntW-1:0] HcntSat  = HcntW'(LONG_PRESS_CYCLES);
   localparam logic [HcntW-1:0] HcntFire = HcntW'(LONG_PRESS_CYCLES - 1);

   logic [HcntW-1:0] hcnt_q, hcnt_d;
   logic             long_pulse_q, long_pulse_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hcnt_q       <= '0;
         long_pulse_q <= 1'b0;
      end else begin
         hcnt_q       <= hcnt_d;
         long_pulse_q <= long_pulse_d;
      end
   end

   // Saturating at LONG_PRESS_CYCLES (one past the fire value) limits the pulse to once per press.
   always_comb begin
      hcnt_d       = hcnt_q;
      long_pulse_d = 1'b0;
      if (press_pulse_d) begin
         hcnt_d       = '0;
         long_pulse_d = (LONG_PRESS_CYCLES == 1);
      end else if ((state_q == StHeld || state_q == StReleaseWait) && hcnt_q != HcntSat) begin
         hcnt_d       = hcnt_q + HcntW'(1);
         long_pulse_d = (hcnt_d == HcntFire);
      end
   end

   assign btn_if.long_pulse = long_pulse_q;
`else
   assign btn_if.long_pulse = 1'b0;
`endif

   assign btn_if.pressed       = pressed_q;
   assign btn_if.press_pulse   = press_pulse_q;
   assign btn_if.release_pulse = release_pulse_q;
   assign btn_if.toggle        = toggle_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: directed scenarios plus randomized button activity
// compared cycle by cycle against a run-length reference model.
module tb_button_debouncer;

   localparam int unsigned D = 4;
   localparam int unsigned L = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   button_debouncer_if bif ();

   button_debouncer #(
      .DEBOUNCE_CYCLES   (D),
      .LONG_PRESS_CYCLES (L)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .btn_if (bif.slave)
   );

   wire [4:0] obs = {bif.pressed, bif.press_pulse, bif.release_pulse, bif.long_pulse, bif.toggle};

   int n_vec = 0;
   int n_err = 0;

   // Reference model: acceptance after D+1 consecutive opposite samples of the synced level.
   bit m_s1, m_s2, m_lvl, m_tog, e_pp, e_rp, e_lp;
   int m_run, m_age;

   function automatic void model_reset();
      m_s1 = 1'b1; m_s2 = 1'b1; m_lvl = 1'b0; m_tog = 1'b0;
      m_run = 0; m_age = 0; e_pp = 1'b0; e_rp = 1'b0; e_lp = 1'b0;
   endfunction

   function automatic logic [4:0] expv();
      return {m_lvl, e_pp, e_rp, e_lp, m_tog};
   endfunction

   task automatic model_edge();
      bit s, prev;
      if (rst) begin
         model_reset();
         return;
      end
      s    = ~m_s2;
      m_s2 = m_s1;
      m_s1 = bif.btn_n;
      e_pp = 1'b0; e_rp = 1'b0; e_lp = 1'b0;
      prev = m_lvl;
      if (s != m_lvl) m_run++;
      else m_run = 0;
      if (m_run == int'(D) + 1) begin
         m_lvl = s;
         m_run = 0;
         if (s) begin
            e_pp  = 1'b1;
            m_tog = ~m_tog;
            m_age = 0;
         end else begin
            e_rp = 1'b1;
         end
      end
      if (prev) begin
         m_age++;
`ifdef LONG_PRESS_EN
         if (m_age == int'(L) - 1) e_lp = 1'b1;
`endif
      end
   endtask

   task automatic step(input logic b);
      @(negedge clk);
      bif.btn_n = b;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bif.btn_n = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_vec++;
      if (obs !== 5'b0) begin
         n_err++;
         $display("FAIL reset_values: got %b want 00000", obs);
      end
      for (int i = 0; i < 4; i++) begin
         step(1'b1);
         n_vec++;
         if (obs !== expv()) begin
            n_err++;
            $display("FAIL reset_idle step %0d: got %b want %b", i, obs, expv());
         end
      end
   endtask

   task automatic test_clean_press();
      int found = -1;
      for (int i = 0; i < 12; i++) begin
         step(1'b0);
         n_vec++;
         if (obs !== expv()) begin
            n_err++;
            $display("FAIL clean_press step %0d: got %b want %b", i, obs, expv());
         end
         if (bif.press_pulse === 1'b1 && found < 0) found = i;
      end
      n_vec++;
      if (found != int'(D) + 2) begin
         n_err++;
         $display("FAIL clean_press_latency: got %0d want %0d", found, D + 2);
      end
      n_vec++;
      if (bif.toggle !== 1'b1 || bif.pressed !== 1'b1) begin
         n_err++;
         $display("FAIL clean_press_level: got toggle=%b pressed=%b want 1 1", bif.toggle,
                  bif.pressed);
      end
      for (int i = 0; i < 12; i++) step(1'b1);
   endtask

   task automatic test_bounce();
      int pp = 0;
      for (int r = 0; r < 5; r++) begin
         for (int i = 0; i < 5; i++) begin
            step((i < 3) ? 1'b0 : 1'b1);
            n_vec++;
            if (obs !== expv()) begin
               n_err++;
               $display("FAIL bounce r%0d i%0d: got %b want %b", r, i, obs, expv());
            end
            if (bif.press_pulse === 1'b1 || bif.release_pulse === 1'b1) pp++;
         end
      end
      for (int i = 0; i < 10; i++) begin
         step(1'b1);
         if (bif.press_pulse === 1'b1 || bif.release_pulse === 1'b1) pp++;
      end
      n_vec++;
      if (pp != 0 || bif.pressed !== 1'b0) begin
         n_err++;
         $display("FAIL bounce_reject: got pulses=%0d pressed=%b want 0 0", pp, bif.pressed);
      end
   endtask

   task automatic test_release_bounce();
      int rel_at = -1;
      int n_rel = 0;
      int n_pp = 0;
      logic pat [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 10; i++) step(1'b0);
      for (int i = 0; i < 5; i++) begin
         step(pat[i]);
         n_vec++;
         if (obs !== expv() || bif.pressed !== 1'b1) begin
            n_err++;
            $display("FAIL release_bounce_hold %0d: got %b want %b", i, obs, expv());
         end
      end
      for (int i = 0; i < 12; i++) begin
         step(1'b1);
         n_vec++;
         if (obs !== expv()) begin
            n_err++;
            $display("FAIL release_bounce step %0d: got %b want %b", i, obs, expv());
         end
         if (bif.release_pulse === 1'b1) begin
            n_rel++;
            if (rel_at < 0) rel_at = i;
         end
         if (bif.press_pulse === 1'b1) n_pp++;
      end
      n_vec++;
      if (n_rel != 1 || rel_at != int'(D) + 2 || n_pp != 0) begin
         n_err++;
         $display("FAIL release_latency: got n=%0d at=%0d presses=%0d want 1 %0d 0", n_rel,
                  rel_at, n_pp, D + 2);
      end
   endtask

   task automatic test_long_press();
      do_reset();
      for (int p = 0; p < 2; p++) begin
         int press_at = -1;
         int long_at = -1;
         int n_long = 0;
         for (int i = 0; i < 40; i++) begin
            step(1'b0);
            n_vec++;
            if (obs !== expv()) begin
               n_err++;
               $display("FAIL long_press p%0d step %0d: got %b want %b", p, i, obs, expv());
            end
            if (bif.press_pulse === 1'b1) press_at = i;
            if (bif.long_pulse === 1'b1) begin
               n_long++;
               long_at = i;
            end
         end
         for (int i = 0; i < 12; i++) begin
            step(1'b1);
            if (bif.long_pulse === 1'b1) n_long++;
         end
`ifdef LONG_PRESS_EN
         n_vec++;
         if (n_long != 1 || long_at - press_at != int'(L) - 1) begin
            n_err++;
            $display("FAIL long_pulse p%0d: got n=%0d offset=%0d want 1 %0d", p, n_long,
                     long_at - press_at, L - 1);
         end
`else
         n_vec++;
         if (n_long != 0 || press_at != int'(D) + 2) begin
            n_err++;
            $display("FAIL long_disabled p%0d: got n=%0d press_at=%0d want 0 %0d", p, n_long,
                     press_at, D + 2);
         end
`endif
      end
      n_vec++;
      if (bif.toggle !== 1'b0) begin
         n_err++;
         $display("FAIL long_toggle: got %b want 0", bif.toggle);
      end
   endtask

   task automatic test_reset_mid_press();
      int found = -1;
      for (int i = 0; i < 10; i++) step(1'b0);
      for (int i = 0; i < 12; i++) step(1'b1);
      for (int i = 0; i < 3; i++) step(1'b0);
      #2 rst = 1'b1;
      model_reset();
      #1;
      n_vec++;
      if (obs !== 5'b0) begin
         n_err++;
         $display("FAIL async_reset: got %b want 00000", obs);
      end
      step(1'b0);
      rst = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         step(1'b0);
         n_vec++;
         if (obs !== expv()) begin
            n_err++;
            $display("FAIL reset_release step %0d: got %b want %b", i, obs, expv());
         end
         if (bif.press_pulse === 1'b1 && found < 0) found = i;
      end
      n_vec++;
      if (found != int'(D) + 3) begin
         n_err++;
         $display("FAIL reset_release_latency: got %0d want %0d", found, D + 3);
      end
   endtask

   task automatic test_random();
      logic lvl = 1'b1;
      for (int run = 0; run < 300; run++) begin
         int len;
         lvl = ~lvl;
         len = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 30) : $urandom_range(1, 8);
         if ($urandom_range(0, 49) == 0) begin
            #2 rst = 1'b1;
            model_reset();
            step(lvl);
            rst = 1'b0;
         end
         for (int i = 0; i < len; i++) begin
            step(lvl);
            n_vec++;
            if (obs !== expv()) begin
               n_err++;
               $display("FAIL random run %0d step %0d: got %b want %b", run, i, obs, expv());
            end
         end
      end
   endtask

   initial begin
      bif.btn_n = 1'b1;
      model_reset();
      test_reset();
      test_clean_press();
      test_bounce();
      test_release_bounce();
      test_long_press();
      test_reset_mid_press();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
